restoring_divider: RTL and testbench

Parametrised, multi-cycle unsigned restoring divider with a start/done handshake and remainder output. It resolves one quotient bit per clock and sits beside the datapath as a shared arithmetic unit, replacing the fixed 8-bit free-running divider. Over that divider it adds start/busy/done control, a remainder output, divide-by-zero detection, and optional signed operation.

---
 rtl/restoring_divider_if.sv | 23 ++
 rtl/restoring_divider.sv | 162 ++++++++++++++++
 tb/tb_restoring_divider.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/restoring_divider_if.sv
// Request/result bundle for restoring_divider: start handshake, operands in, results and status out.
interface restoring_divider_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/restoring_divider.sv
// Multi-cycle restoring divider resolving one quotient bit per clock, with start/busy/done handshake.
// Define SIGNED_DIV_EN for two's-complement operation (truncating division); default is unsigned only.
module restoring_divider #(
  parameter int WIDTH = 8
) (
  input logic          clk,
  input logic          rst,
  restoring_divider_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_next;

  // The partial remainder stays below the divisor, so only its low WIDTH bits need storing;
  // the extra bit of A exists only in the shifted/trial values.
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] den;
  logic [CW-1:0]    count;

  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             dbz_q;

  logic             load;
  logic             step;
  logic             finish;
  logic             zero_finish;

  logic [WIDTH:0]   a_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] a_step;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] q_res;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] z_rem;

`ifdef SIGNED_DIV_EN
  logic sign_q;
  logic sign_r;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // A zero divisor skips RUN; DONE then spends one cycle publishing the result before pulsing done.
  always_comb begin
    state_next  = state;
    load        = 1'b0;
    step        = 1'b0;
    finish      = 1'b0;
    zero_finish = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = (bus.divisor == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (count == CW'(WIDTH - 1)) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (done_q) state_next  = IDLE;
        else        zero_finish = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    a_shift = {acc, quo[WIDTH-1]};
    trial   = a_shift - {1'b0, den};
    a_step  = trial[WIDTH] ? a_shift[WIDTH-1:0] : trial[WIDTH-1:0];
    q_step  = {quo[WIDTH-2:0], ~trial[WIDTH]};
`ifdef SIGNED_DIV_EN
    dvd_mag = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    dvs_mag = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
    q_res   = sign_q ? -q_step : q_step;
    r_res   = sign_r ? -a_step : a_step;
    z_rem   = sign_r ? -quo    : quo;
`else
    dvd_mag = bus.dividend;
    dvs_mag = bus.divisor;
    q_res   = q_step;
    r_res   = a_step;
    z_rem   = quo;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc         <= '0;
      quo         <= '0;
      den         <= '0;
      count       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
`ifdef SIGNED_DIV_EN
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      busy_q <= (state_next != IDLE);
      if (load) begin
        acc   <= '0;
        quo   <= dvd_mag;
        den   <= dvs_mag;
        count <= '0;
`ifdef SIGNED_DIV_EN
        sign_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
        sign_r <= bus.dividend[WIDTH-1];
`endif
      end
      if (step) begin
        acc   <= a_step;
        quo   <= q_step;
        count <= count + CW'(1);
      end
      if (finish) begin
        quotient_q  <= q_res;
        remainder_q <= r_res;
        dbz_q       <= 1'b0;
        done_q      <= 1'b1;
      end
      if (zero_finish) begin
        quotient_q  <= '1;
        remainder_q <= z_rem;
        dbz_q       <= 1'b1;
        done_q      <= 1'b1;
      end
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider.sv
// Directed self-checking bench for restoring_divider: WIDTH=8 and WIDTH=16 instances on a shared clock/reset.
// Signed vectors are added when SIGNED_DIV_EN is defined.
module tb_restoring_divider;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  restoring_divider_if #(.WIDTH(8))  bus8 ();
  restoring_divider_if #(.WIDTH(16)) bus16 ();

  restoring_divider #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  restoring_divider #(.WIDTH(16)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One start pulse, then wait (bounded) for done and check latency, results and the busy/done tail.
  task automatic applyStimulus(input bit wide, input logic [15:0] dvd, input logic [15:0] dvs,
                               input logic [15:0] exp_q, input logic [15:0] exp_r, input logic exp_z,
                               input int exp_lat, input string tag);
    int   n;
    logic dn;
    if (wide) begin
      bus16.dividend = dvd;
      bus16.divisor  = dvs;
      bus16.start    = 1'b1;
    end else begin
      bus8.dividend = dvd[7:0];
      bus8.divisor  = dvs[7:0];
      bus8.start    = 1'b1;
    end
    tick();
    bus8.start  = 1'b0;
    bus16.start = 1'b0;
    n  = 1;
    dn = wide ? bus16.done : bus8.done;
    while (!dn && n < 60) begin
      tick();
      n++;
      dn = wide ? bus16.done : bus8.done;
    end
    checkOutput({tag, " latency"}, n, exp_lat);
    if (wide) begin
      checkOutput({tag, " quotient"},  bus16.quotient,    exp_q);
      checkOutput({tag, " remainder"}, bus16.remainder,   exp_r);
      checkOutput({tag, " dbz"},       bus16.div_by_zero, exp_z);
      checkOutput({tag, " busy@done"}, bus16.busy,        1);
    end else begin
      checkOutput({tag, " quotient"},  bus8.quotient,     {8'h00, exp_q[7:0]});
      checkOutput({tag, " remainder"}, bus8.remainder,    {8'h00, exp_r[7:0]});
      checkOutput({tag, " dbz"},       bus8.div_by_zero,  exp_z);
      checkOutput({tag, " busy@done"}, bus8.busy,         1);
    end
    tick();
    checkOutput({tag, " done pulse"}, wide ? bus16.done : bus8.done, 0);
    checkOutput({tag, " busy after"}, wide ? bus16.busy : bus8.busy, 0);
  endtask

  initial begin
    int n;
    int dones;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus8.start  = 1'b0; bus8.dividend  = '0; bus8.divisor  = '0;
    bus16.start = 1'b0; bus16.dividend = '0; bus16.divisor = '0;
    tick();
    tick();
    checkOutput("reset busy",      bus8.busy,        0);
    checkOutput("reset done",      bus8.done,        0);
    checkOutput("reset quotient",  bus8.quotient,    0);
    checkOutput("reset remainder", bus8.remainder,   0);
    checkOutput("reset dbz",       bus8.div_by_zero, 0);
    rst = 1'b0;
    tick();

    $display("[TB] basic unsigned and divide-by-zero");
    applyStimulus(0, 16'd100, 16'd7, 16'd14,  16'd2,  0, 9, "100/7");
    applyStimulus(0, 16'd37,  16'd0, 16'd255, 16'd37, 1, 2, "37/0");
    applyStimulus(0, 16'd255, 16'd16, 16'd15, 16'd15, 0, 9, "255/16");

    $display("[TB] 16-bit boundaries");
    applyStimulus(1, 16'd65535, 16'd1,     16'd65535, 16'd0, 0, 17, "65535/1");
    applyStimulus(1, 16'd5,     16'd9,     16'd0,     16'd5, 0, 17, "5/9");
    applyStimulus(1, 16'd65535, 16'd65535, 16'd1,     16'd0, 0, 17, "65535/65535");

    $display("[TB] start while busy is ignored");
    bus8.dividend = 8'd50; bus8.divisor = 8'd5; bus8.start = 1'b1;
    tick(); n = 1; bus8.start = 1'b0;
    tick(); n = 2;
    tick(); n = 3;
    bus8.dividend = 8'd200; bus8.divisor = 8'd3; bus8.start = 1'b1;
    tick(); n = 4; bus8.start = 1'b0;
    while (!bus8.done && n < 60) begin
      tick();
      n++;
    end
    checkOutput("busy-ignore latency",   n,              9);
    checkOutput("busy-ignore quotient",  bus8.quotient,  10);
    checkOutput("busy-ignore remainder", bus8.remainder, 0);
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus8.done) dones++;
    end
    checkOutput("busy-ignore no 2nd done", dones, 0);
    checkOutput("busy-ignore idle",        bus8.busy, 0);

    $display("[TB] reset during RUN");
    dones = 0;
    bus8.dividend = 8'd50; bus8.divisor = 8'd5; bus8.start = 1'b1;
    tick(); bus8.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus8.done) dones++;
    end
    rst = 1'b1;
    tick();
    checkOutput("midrst busy",      bus8.busy,        0);
    checkOutput("midrst done",      bus8.done,        0);
    checkOutput("midrst quotient",  bus8.quotient,    0);
    checkOutput("midrst remainder", bus8.remainder,   0);
    checkOutput("midrst dbz",       bus8.div_by_zero, 0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus8.done) dones++;
    end
    checkOutput("midrst no done", dones, 0);
    applyStimulus(0, 16'd9, 16'd2, 16'd4, 16'd1, 0, 9, "9/2 after rst");

`ifdef SIGNED_DIV_EN
    $display("[TB] signed vectors");
    applyStimulus(0, 16'h009C, 16'h0007, 16'h00F2, 16'h00FE, 0, 9, "-100/7");
    applyStimulus(0, 16'h0080, 16'h00FF, 16'h0080, 16'h0000, 0, 9, "-128/-1");
    applyStimulus(0, 16'h00F6, 16'h0000, 16'h00FF, 16'h00F6, 1, 2, "-10/0");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
